// File: rtl/fifo_pkg.sv
// Shared types for the fifo family: state encoding of the burst drain consumer.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } burst_drain_state_e;

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO with empty/almost-empty/full flags and a synchronous flush.
// Head entry is visible on data_o; a push while full is dropped, a pop while empty is ignored.
module fifo #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned AEMPTY_LEVEL = 1,
    parameter type         dtype        = logic [DATA_WIDTH-1:0]
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic push_i,
    input  dtype data_i,
    input  logic pop_i,
    output dtype data_o,
    output logic full_o,
    output logic empty_o,
    output logic aempty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    dtype             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] usage_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o   = (usage_q == CNT_W'(DEPTH));
    assign empty_o  = (usage_q == '0);
    assign aempty_o = (usage_q <= CNT_W'(AEMPTY_LEVEL));
    assign do_push  = push_i & ~full_o;
    assign do_pop   = pop_i & ~empty_o;
    assign data_o   = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop) begin
                usage_q <= usage_q + 1'b1;
            end else if (!do_push && do_pop) begin
                usage_q <= usage_q - 1'b1;
            end
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fifo_burst_drain.sv
// Pops fixed-length bursts from a fifo read port onto a valid/ready stream with a last marker.
// Define FIFO_BURST_DRAIN_TIMEOUT_EN to drain residual data as single beats after an idle timeout.
//
// state | meaning
// IDLE  | waiting for BURST_LEN entries (or for the residual timeout)
// BURST | streaming BURST_LEN beats, last on the final one
// DRAIN | single-beat bursts emptying residual data (timeout build only)
module fifo_burst_drain
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned BURST_LEN      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter type         dtype          = logic [DATA_WIDTH-1:0]
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic fifo_empty_i,
    input  logic fifo_aempty_i,
    input  dtype fifo_data_i,
    output logic fifo_pop_o,
    output logic out_valid_o,
    input  logic out_ready_i,
    output dtype out_data_o,
    output logic out_last_o
);

    localparam int unsigned          BEAT_W    = $clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0]    BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    if ((BURST_LEN < 2) || (BURST_LEN > DEPTH)) begin : g_bad_burst_len
        $error("fifo_burst_drain: BURST_LEN must lie in 2..DEPTH");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fifo_burst_drain: TIMEOUT_CYCLES must be at least 1");
    end

    burst_drain_state_e state_q;
    burst_drain_state_e state_d;
    logic [BEAT_W-1:0]  beat_q;
    logic [BEAT_W-1:0]  beat_d;
    logic               handshake;
    logic               burst_ready;

    assign out_data_o  = fifo_data_i;
    assign handshake   = out_valid_o & out_ready_i;
    assign fifo_pop_o  = handshake;
    assign burst_ready = !fifo_aempty_i && !fifo_empty_i;

`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
    localparam int unsigned       TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q;
    logic [TMO_W-1:0] tmo_d;
    logic             residual;

    assign residual = !fifo_empty_i && fifo_aempty_i;
`endif

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (burst_ready) begin
                    state_d = BURST;
                    beat_d  = '0;
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
                    tmo_d   = '0;
                end else if (residual) begin
                    if (tmo_q == TMO_LAST) begin
                        state_d = DRAIN;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end else begin
                    tmo_d = '0;
`endif
                end
            end
            BURST: begin
                out_valid_o = 1'b1;
                out_last_o  = (beat_q == BEAT_LAST);
                if (handshake) begin
                    if (beat_q == BEAT_LAST) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
            DRAIN: begin
                out_valid_o = !fifo_empty_i;
                out_last_o  = 1'b1;
                // Leave once empty, or hand over to a full burst when no beat is stalled.
                if (fifo_empty_i || (!fifo_aempty_i && out_ready_i)) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase

        if (flush_i) begin
            state_d = IDLE;
            beat_d  = '0;
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
            tmo_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // Sole consumer: a burst only starts with BURST_LEN entries present, so it never runs dry.
    a_burst_not_empty: assert property (
        @(posedge clk_i) disable iff (!rst_ni) (state_q == BURST) |-> !fifo_empty_i
    ) else $error("fifo_burst_drain: fifo empty during a burst");

endmodule
